// File: rtl/capture_reduce_unit.sv
// Operand capture buffer with a sequential N-step reduction (sum / max / min / average).
// Operands are loaded by index while capture is high; the falling edge of capture starts the reduction.
module capture_reduce_unit #(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int RW = W + $clog2(N)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 capture,
  input  logic [$clog2(N)-1:0] op,
  input  logic [W-1:0]         d_in,
  input  logic [1:0]           mode,
  output logic [RW-1:0]        result,
  output logic                 valid,
  output logic                 busy,
  output logic                 err,
  output logic [1:0]           o_dbg_state
);

  localparam int LG = $clog2(N);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [1:0]    M_SUM    = 2'b00;
  localparam logic [1:0]    M_MAX    = 2'b01;
  localparam logic [1:0]    M_MIN    = 2'b10;
  localparam logic [1:0]    M_AVG    = 2'b11;
  localparam logic [LG-1:0] LAST_IDX = LG'(N - 1);
  localparam logic [RW-1:0] MIN_INIT = RW'({W{1'b1}});

  state_t          r_state;
  logic [W-1:0]    r_ops [N];
  logic [N-1:0]    r_mask;
  logic            r_prev_cap;
  logic [1:0]      r_mode;
  logic [LG-1:0]   r_idx;
  logic [RW-1:0]   r_acc;
  logic [RW-1:0]   r_result;
  logic            r_valid;
  logic            r_busy;
  logic            r_err;

  logic [RW-1:0]   w_opnd;
  logic [RW-1:0]   w_acc_next;
  logic [RW-1:0]   w_final;
  logic            w_write;
  logic            w_sess_start;
  logic [N-1:0]    w_op_bit;

  assign w_opnd   = RW'(r_ops[r_idx]);
  assign w_op_bit = N'(1) << op;

  // A capture in DONE always opens a new session; in LOAD only the first
  // capture after an idle cycle does, later ones extend the current session.
  assign w_write      = capture && (r_state != S_COMPUTE);
  assign w_sess_start = capture && ((r_state == S_DONE) ||
                                    ((r_state == S_LOAD) && !r_prev_cap));

  always_comb begin
    w_acc_next = r_acc;
    case (r_mode)
      M_SUM, M_AVG: w_acc_next = r_acc + w_opnd;
      M_MAX:        w_acc_next = (w_opnd > r_acc) ? w_opnd : r_acc;
      M_MIN:        w_acc_next = (w_opnd < r_acc) ? w_opnd : r_acc;
      default:      w_acc_next = r_acc;
    endcase
  end

  // N is a power of two, so the average is a plain truncating shift.
  assign w_final = (r_mode == M_AVG) ? (w_acc_next >> LG) : w_acc_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_LOAD;
      for (int i = 0; i < N; i++) r_ops[i] <= '0;
      r_mask     <= '0;
      r_prev_cap <= 1'b0;
      r_mode     <= M_SUM;
      r_idx      <= '0;
      r_acc      <= '0;
      r_result   <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD, S_DONE: begin
          if (w_write) begin
            for (int i = 0; i < N; i++) begin
              if (i == int'(op)) begin
                r_ops[i] <= d_in;
              end else if (w_sess_start) begin
                r_ops[i] <= '0;
              end
            end
            r_mask     <= (w_sess_start ? '0 : r_mask) | w_op_bit;
            r_prev_cap <= 1'b1;
            r_state    <= S_LOAD;
            if (w_sess_start) begin
              r_valid <= 1'b0;
              r_err   <= 1'b0;
            end
          end else if ((r_state == S_LOAD) && r_prev_cap) begin
            r_state    <= S_COMPUTE;
            r_busy     <= 1'b1;
            r_idx      <= '0;
            r_mode     <= mode;
            r_err      <= ~&r_mask;
            r_acc      <= (mode == M_MIN) ? MIN_INIT : '0;
            r_prev_cap <= 1'b0;
          end
        end
        S_COMPUTE: begin
          r_acc <= w_acc_next;
          r_idx <= r_idx + LG'(1);
          if (r_idx == LAST_IDX) begin
            r_result <= w_final;
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

  assign result      = r_result;
  assign valid       = r_valid;
  assign busy        = r_busy;
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule
